window_7x7_gen: RTL and testbench

Raster-scan sliding-window generator that sits directly upstream of the 7x7 centre-intensity binarisation stage. It accepts one pixel per accepted cycle in row-major order and buffers six image lines in internal line memories. It presents a complete 7x7 neighbourhood, plus the centre-pixel coordinates, whenever a fully populated window exists. Only interior windows are produced; there is no border padding.

---
 rtl/window_7x7_gen.sv | 77 +++++++
 tb/tb_window_7x7_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/window_7x7_gen.sv
// window_7x7_gen: raster-scan 7x7 sliding-window generator with six line buffers.
// Optional FRAME_SYNC_EN adds i_sof to force the accepted pixel to (0,0).
module window_7x7_gen #(
  parameter int WIDTH = 8,
  parameter int IMG_WIDTH = 128,
  parameter int IMG_HEIGHT = 128,
  localparam int CW = $clog2(IMG_WIDTH),
  localparam int RW = $clog2(IMG_HEIGHT)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [WIDTH-1:0]  i_pixel,
`ifdef FRAME_SYNC_EN
  input  logic              i_sof,
`endif
  output logic              o_valid,
  output logic [49*WIDTH-1:0] o_window,
  output logic [RW-1:0]     o_row,
  output logic [CW-1:0]     o_col,
  output logic              o_eof
);
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic [WIDTH-1:0] lb [6][IMG_WIDTH];
  logic [WIDTH-1:0] win [7][7];
  logic [WIDTH-1:0] new_col [7];
  logic last_col, last_row, hit;
`ifdef FRAME_SYNC_EN
  assign cur_col = i_sof ? '0 : col;
  assign cur_row = i_sof ? '0 : row;
`else
  assign cur_col = col;
  assign cur_row = row;
`endif
  assign last_col = cur_col == CW'(IMG_WIDTH - 1);
  assign last_row = cur_row == RW'(IMG_HEIGHT - 1);
  // Columns 0..5 only prime the array, so a window never straddles two lines.
  assign hit = i_valid && cur_row >= RW'(6) && cur_col >= CW'(6);
  always_comb begin
    for (int k = 0; k < 6; k++) new_col[k] = lb[k][cur_col];
    new_col[6] = i_pixel;
  end
  always_ff @(posedge i_clk)
    if (i_valid)
      for (int k = 0; k < 6; k++) lb[k][cur_col] <= new_col[k+1];
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      col <= '0;
      row <= '0;
      win <= '{default: '{default: '0}};
      o_valid <= 1'b0;
      o_eof <= 1'b0;
      o_row <= '0;
      o_col <= '0;
    end else begin
      o_valid <= hit;
      o_eof <= hit && last_row && last_col;
      if (i_valid) begin
        col <= last_col ? '0 : cur_col + CW'(1);
        row <= last_col ? (last_row ? '0 : cur_row + RW'(1)) : cur_row;
        for (int r = 0; r < 7; r++) begin
          for (int c = 0; c < 6; c++) win[r][c] <= win[r][c+1];
          win[r][6] <= new_col[r];
        end
      end
      if (hit) begin
        o_row <= cur_row - RW'(3);
        o_col <= cur_col - CW'(3);
      end
    end
  for (genvar r = 0; r < 7; r++) begin : g_r
    for (genvar c = 0; c < 7; c++) begin : g_c
      assign o_window[(r*7+c)*WIDTH +: WIDTH] = win[r][c];
    end
  end
endmodule

// File: tb/tb_window_7x7_gen.sv
// tb_window_7x7_gen: scoreboard bench for window_7x7_gen on an 8x8 image.
module tb_window_7x7_gen;
  localparam int W = 8, IW = 8, IH = 8;
  typedef struct {
    logic [49*W-1:0] w;
    logic [2:0] r, c;
    logic eof;
    int cyc;
  } exp_t;
  logic i_clk = 0, i_rst = 1, i_valid = 0;
  logic [W-1:0] i_pixel = '0;
`ifdef FRAME_SYNC_EN
  logic i_sof = 0;
`endif
  logic o_valid, o_eof;
  logic [49*W-1:0] o_window;
  logic [2:0] o_row, o_col;
  int checks = 0, failures = 0, cyc = 0, popped = 0, mr = 0, mc = 0;
  logic last_iv = 0;
  exp_t q[$];

  window_7x7_gen #(.WIDTH(W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_pixel(i_pixel),
`ifdef FRAME_SYNC_EN
    .i_sof(i_sof),
`endif
    .o_valid(o_valid), .o_window(o_window), .o_row(o_row), .o_col(o_col), .o_eof(o_eof)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    last_iv <= i_valid;
  end

  task automatic chk(input string name, input logic [49*W-1:0] act, input logic [49*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Pixel value of frame "base" at (r,c); the model tracks coordinates independently of the DUT.
  function automatic logic [W-1:0] pix(input logic [W-1:0] base, input int r, input int c);
    return base + W'(r * 16 + c);
  endfunction

  task automatic send(input logic [W-1:0] base, input bit gaps, input bit sof);
    exp_t e;
    if (gaps) repeat ($urandom_range(0, 2)) @(posedge i_clk) #1;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
`ifdef FRAME_SYNC_EN
    i_sof = sof;
`endif
    i_valid = 1;
    i_pixel = pix(base, mr, mc);
    if (mr >= 6 && mc >= 6) begin
      for (int i = 0; i < 7; i++)
        for (int j = 0; j < 7; j++)
          e.w[(i*7+j)*W +: W] = pix(base, mr - 6 + i, mc - 6 + j);
      e.r = 3'(mr - 3);
      e.c = 3'(mc - 3);
      e.eof = (mr == IH - 1) && (mc == IW - 1);
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    @(posedge i_clk) #1;
    i_valid = 0;
`ifdef FRAME_SYNC_EN
    i_sof = 0;
`endif
    if (mc == IW - 1) begin
      mc = 0;
      mr = (mr == IH - 1) ? 0 : mr + 1;
    end else mc++;
  endtask

  task automatic frame(input logic [W-1:0] base, input bit gaps);
    for (int n = 0; n < IW * IH; n++) send(base, gaps, 0);
  endtask

  task automatic expect_windows(input string name, input int p0, input int n);
    repeat (4) @(posedge i_clk);
    #1;
    chk({name, "_count"}, (49*W)'(popped - p0), (49*W)'(n));
    chk({name, "_drained"}, (49*W)'(q.size()), '0);
  endtask

  always @(negedge i_clk)
    if (o_valid) begin
      chk("valid_after_idle", (49*W)'(last_iv), (49*W)'(1));
      if (q.size() == 0) chk("unexpected_window", (49*W)'(o_valid), '0);
      else begin
        exp_t e;
        e = q.pop_front();
        popped++;
        chk("window", o_window, e.w);
        chk("row", (49*W)'(o_row), (49*W)'(e.r));
        chk("col", (49*W)'(o_col), (49*W)'(e.c));
        chk("eof", (49*W)'(o_eof), (49*W)'(e.eof));
        chk("latency", (49*W)'(cyc), (49*W)'(e.cyc));
      end
    end else if (o_eof) chk("eof_without_valid", (49*W)'(o_eof), '0);

  initial begin
    int p0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", (49*W)'(o_valid), '0);
    chk("rst_eof", (49*W)'(o_eof), '0);
    chk("rst_window", o_window, '0);
    chk("rst_row", (49*W)'(o_row), '0);
    chk("rst_col", (49*W)'(o_col), '0);
    i_rst = 0;
    @(posedge i_clk) #1;
    // Frame 1, continuous: spot-check the first window right after pixel 0x66.
    p0 = popped;
    for (int n = 0; n < IW * IH; n++) begin
      send(8'h00, 0, 0);
      if (n == 54) begin
        chk("first_valid", (49*W)'(o_valid), (49*W)'(1));
        chk("first_w00", (49*W)'(o_window[0 +: W]), (49*W)'(8'h00));
        chk("first_w33", (49*W)'(o_window[24*W +: W]), (49*W)'(8'h33));
        chk("first_w66", (49*W)'(o_window[48*W +: W]), (49*W)'(8'h66));
        chk("first_row", (49*W)'(o_row), (49*W)'(3));
        chk("first_col", (49*W)'(o_col), (49*W)'(3));
      end
      if (n == 63) begin
        chk("last_eof", (49*W)'(o_eof), (49*W)'(1));
        chk("last_w66", (49*W)'(o_window[48*W +: W]), (49*W)'(8'h77));
      end
    end
    expect_windows("cont", p0, 4);
    p0 = popped;
    frame(8'h00, 1);
    expect_windows("gaps", p0, 4);
    p0 = popped;
    frame(8'h00, 0);
    frame(8'h80, 0);
    expect_windows("b2b", p0, 8);
    // Reset after 30 pixels, then a full fresh frame.
    p0 = popped;
    for (int n = 0; n < 30; n++) send(8'h00, 0, 0);
    i_rst = 1;
    #2;
    chk("midrst_valid", (49*W)'(o_valid), '0);
    chk("midrst_window", o_window, '0);
    @(posedge i_clk) #1;
    i_rst = 0;
    mr = 0;
    mc = 0;
    frame(8'h40, 0);
    expect_windows("midrst", p0, 4);
`ifdef FRAME_SYNC_EN
    // Abandon a frame after two windows; only the new frame's four windows may follow.
    p0 = popped;
    for (int n = 0; n < 60; n++) send(8'h00, 0, 0);
    send(8'h20, 0, 1);
    for (int n = 1; n < IW * IH; n++) send(8'h20, 0, 0);
    expect_windows("sof", p0, 6);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
